// File: rtl/odata_uart_pkg.sv
// odata_uart_pkg: shared state type and constants for the ODATA UART transmitter
package odata_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam int DEFAULT_BAUD_DIV = 434;
    localparam int FRAME_BITS = 10;
endpackage

// File: rtl/odata_tx_fifo.sv
// odata_tx_fifo: small byte queue between the PIO send edge and the serial shifter
module odata_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    assign rdata = mem_q[rptr_q];
    assign full  = count_q == FULL_CNT;
    assign empty = count_q == '0;
    assign count = count_q;
    // push may coincide with a pop while full; the caller drops pushes otherwise
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
    // storage and pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q   <= '{default: '0};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/odata_uart_tx.sv
// odata_uart_tx: queues bytes from the ODATA PIO and shifts them out as 8N1 frames
module odata_uart_tx
    import odata_uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    data_in,
    input  logic                          send_req,
    input  logic                          clr_overflow,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d, head;
    logic        tx_q, tx_d, send_q, overflow_q, overflow_d;
    logic        push, pop, drop, fifo_empty;
    assign push     = send_req & ~send_q;
    assign drop     = push & fifo_full & ~pop;
    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign tx_busy  = (state_q != IDLE) | ~fifo_empty;
    odata_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push & ~drop),
        .pop     (pop),
        .wdata   (data_in),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );
    // frame sequencer: each bit lasts BAUD_DIV cycles; STOP chains straight into the next START
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE) ? baud_q : baud_q - 16'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                shreg_d = head;
                baud_d  = BAUD_RELOAD;
                state_d = START;
            end
            START: if (baud_q == '0) begin
                baud_d  = BAUD_RELOAD;
                bit_d   = '0;
                state_d = DATA;
            end
            DATA: if (baud_q == '0) begin
                shreg_d = shreg_q >> 1;
                baud_d  = BAUD_RELOAD;
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (baud_q == '0) begin
                pop     = ~fifo_empty;
                shreg_d = fifo_empty ? shreg_q : head;
                baud_d  = BAUD_RELOAD;
                state_d = fifo_empty ? IDLE : START;
            end
        endcase
        tx_d       = (state_d == START) ? 1'b0 : (state_d == DATA) ? shreg_d[0] : 1'b1;
        overflow_d = drop ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
    end
    // state registers; send_q resets high so a request held through reset is ignored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            send_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            send_q     <= send_req;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_odata_uart_tx.sv
// tb_odata_uart_tx: scoreboard bench with a timestamp-based model of the transmitter
module tb_odata_uart_tx;
    localparam int BD    = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BD;
    logic       clk = 1'b0, reset_n = 1'b1, send_req = 1'b0, clr_overflow = 1'b0;
    logic [7:0] data_in = '0;
    logic       tx, tx_busy, fifo_full, overflow;
    logic [2:0] fifo_count;
    int tests = 0, errors = 0, cyc = 0, rst_gen = 0;
    bit chk_en = 1'b0;
    typedef struct {int c; int cnt; bit busy; bit ovf;} st_t;
    typedef struct {logic [7:0] d; int st;} fr_t;
    st_t sq[$];
    fr_t fq[$];
    int  push_t[$], pop_t[$];
    bit  m_prev = 1'b1, m_ovf = 1'b0;
    st_t ms;
    fr_t f_e;
    int  f_st, f_g;
    logic [9:0] f_b;

    odata_uart_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .send_req     (send_req),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // bytes waiting in the queue during cycle c: accepted before c, not yet popped
    function automatic int occ(int c);
        int n = 0;
        foreach (push_t[i]) if (push_t[i] < c && pop_t[i] >= c) n++;
        return n;
    endfunction

    function automatic bit busy_at(int c);
        foreach (push_t[i]) if (push_t[i] < c && c <= pop_t[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit popping(int c);
        foreach (pop_t[i]) if (pop_t[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // one clock of stimulus; pop cycle of an accepted byte = max(push+1, previous pop + one frame)
    task automatic step(bit s, logic [7:0] d, bit clr);
        int k, p;
        bit drop;
        @(posedge clk);
        #1;
        k = cyc;
        drop = 1'b0;
        sq.push_back('{k, occ(k), busy_at(k), m_ovf});
        send_req = s;
        data_in = d;
        clr_overflow = clr;
        if (s && !m_prev) begin
            if (occ(k) < DEPTH || popping(k)) begin
                p = k + 1;
                if (pop_t.size() > 0 && pop_t[$] + FRAME > p) p = pop_t[$] + FRAME;
                push_t.push_back(k);
                pop_t.push_back(p);
                fq.push_back('{d, p + 1});
            end else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_prev = s;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset(bit s_hold);
        chk_en = 1'b0;
        rst_gen++;
        send_req = s_hold;
        clr_overflow = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("reset_tx", tx, 1);
        chk("reset_count", fifo_count, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_full", fifo_full, 0);
        chk("reset_overflow", overflow, 0);
        sq.delete();
        fq.delete();
        push_t.delete();
        pop_t.delete();
        m_ovf = 1'b0;
        m_prev = s_hold;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        chk_en = 1'b1;
    endtask

    // status monitor: compares the registered outputs of each cycle against the model
    initial forever begin
        @(negedge clk);
        while (chk_en && sq.size() > 0 && sq[0].c <= cyc) begin
            ms = sq.pop_front();
            if (ms.c == cyc) begin
                chk("fifo_count", fifo_count, ms.cnt);
                chk("fifo_full", fifo_full, int'(ms.cnt == DEPTH));
                chk("tx_busy", tx_busy, ms.busy);
                chk("overflow", overflow, ms.ovf);
            end
        end
    end

    // line monitor: a UART receiver sampling mid-bit, checked against the expected frame queue
    initial forever begin
        @(negedge clk);
        if (chk_en && tx === 1'b0) begin
            f_st = cyc;
            f_g = rst_gen;
            f_b = '0;
            for (int i = 0; i < 10; i++) begin
                repeat (i == 0 ? BD / 2 : BD) @(negedge clk);
                if (f_g != rst_gen) break;
                f_b[i] = tx;
            end
            if (f_g == rst_gen) begin
                chk("frame_expected", int'(fq.size() > 0), 1);
                if (fq.size() > 0) begin
                    f_e = fq.pop_front();
                    chk("start_cycle", f_st, f_e.st);
                    chk("start_bit", f_b[0], 0);
                    chk("data_bits", f_b[8:1], f_e.d);
                    chk("stop_bit", f_b[9], 1);
                end
            end
        end
    end

    initial begin
        int base, target;
        #2;
        do_reset(1'b0);
        step(1'b1, 8'hA5, 1'b0);
        idle(50);
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        idle(90);
        repeat (6) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            step(1'b0, 8'h00, 1'b0);
        end
        idle(20);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h5A, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        idle(10);
        step(1'b0, 8'h00, 1'b1);
        idle(220);
        repeat (100) step(1'b1, 8'h3C, 1'b0);
        idle(10);
        step(1'b1, 8'hF0, 1'b0);
        idle(18);
        do_reset(1'b1);
        repeat (60) step(1'b1, 8'h77, 1'b0);
        idle(5);
        base = pop_t.size();
        repeat (5) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            step(1'b0, 8'h00, 1'b0);
        end
        target = pop_t[base + 1];
        while (cyc + 1 < target) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h99, 1'b0);
        idle(260);
        repeat (80) step($urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
        idle(450);
        chk("frames_pending", fq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/odata_uart_tx.md
# odata_uart_tx

Byte-serial transmitter fed by the 8-bit ODATA PIO output port. Software writes a byte to the ODATA PIO, then raises a send request through a control PIO bit. The block queues the byte in a small FIFO and shifts it out as an 8N1 asynchronous serial frame. Status outputs are wired back to an input PIO so software can poll for `busy`, `full` and `overflow`.

## Interface
- `BAUD_DIV`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 2..65535.
- `FIFO_DEPTH`, default 4: byte queue depth. Must be a power of two, 2..16.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte from the ODATA PIO `out_port`. Sampled only on a send edge.
- `send_req`  in  1  level from the control PIO. A 0→1 transition queues `data_in`.
- `clr_overflow`  in  1  one-cycle pulse that clears the sticky `overflow` flag.
- `tx`  out  1  serial line. Idles high.
- `tx_busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `fifo_full`  out  1  high when the FIFO holds FIFO_DEPTH bytes.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte currently shifting.
- `overflow`  out  1  sticky flag; set when a send edge arrives while the FIFO is full.

## Operation
- **Send detection.** `send_req` is same-clock (PIO register), so it is not synchronized.
  - A registered copy `send_q` detects rising edges: `push = send_req & ~send_q`.
  - `send_q` resets to 1, so a level already high at reset release never queues a byte.
- **Push.** On `push`, `data_in` is written into the FIFO unless the FIFO is full and no pop occurs in the same cycle.
  - A dropped byte sets `overflow`.
  - If `overflow` set and `clr_overflow` occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If the FIFO is non-empty: pop the head into `shreg`, load `baud_cnt`=BAUD_DIV-1, go to START.
  - **START:** `tx`=0. When `baud_cnt`==0: reload the counter, set `bit_idx`=0, go to DATA.
  - **DATA:** `tx`=`shreg[0]`, so data goes out LSB first. When `baud_cnt`==0: shift `shreg` right and reload the counter. If `bit_idx`==7 go to STOP, else increment `bit_idx`.
  - **STOP:** `tx`=1. When `baud_cnt`==0:
    - FIFO non-empty: pop and go directly to START (no idle gap).
    - FIFO empty: go to IDLE.
- **Registered output.** `tx` is a register driven from the next-state decode, so it is glitch-free.
- **Arithmetic.**
  - `baud_cnt` is 16 bits and counts down.
  - `bit_idx` is 3 bits.
  - FIFO pointers are $clog2(FIFO_DEPTH) bits with natural wrap-around; `fifo_count` tracks occupancy.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
- **Reset values.** `tx`=1, `tx_busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0. FSM=IDLE, FIFO empty.
- **Reset mid-frame.** The frame is abandoned, `tx` returns high immediately (asynchronously), and the queue is discarded.

## Timing
- **Start latency.** Let `send_req` rise in cycle n with the FIFO empty and the FSM in IDLE.
  - Push is registered at the end of cycle n.
  - IDLE pops in cycle n+1.
  - `tx` falls at the start of cycle n+2.
- **Frame length.** Exactly 10×BAUD_DIV cycles: start, then 8 data bits, then stop. Each bit is held exactly BAUD_DIV cycles.
- **Back-to-back.** Bytes follow with zero idle cycles: the next start bit begins the cycle after the last stop-bit cycle.
- **`tx_busy`.** Rises in cycle n+1 (FIFO non-empty). Falls in the cycle after the final stop bit completes with the FIFO empty.
- **Push/pop in the same cycle while full.** The pop makes room, so the byte is accepted and `overflow` stays 0.
- **Held request.** Holding `send_req` high queues exactly one byte. The next byte requires `send_req` to go low for at least one cycle, then high again.

## Structure
- Package `odata_uart_pkg`:
  - state enum `tx_state_t` {IDLE, START, DATA, STOP}
  - constant `DEFAULT_BAUD_DIV`=434
  - constant `FRAME_BITS`=10
- Sub-module `odata_tx_fifo`: synchronous FIFO with FIFO_DEPTH × 8 bits.
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty, count.
- The top level holds the edge detector, the overflow flag, the FSM, the baud counter and the shifter.

## Test plan
All scenarios run with BAUD_DIV=4.
- **Single byte.** Reset, `data_in`=0xA5, pulse `send_req`.
  - `tx` falls 2 cycles after the edge.
  - Line reads 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles.
  - `tx_busy` drops after 40 cycles.
- **Back-to-back.** Queue 0x00 then 0xFF on two edges 2 cycles apart. Two frames are sent with no gap, 80 cycles total; `fifo_count` peaks at 1.
- **Overflow.** Queue 6 bytes while the first is shifting.
  - Bytes 1–5 are transmitted: one shifting plus 4 queued.
  - The 6th is dropped and `overflow`=1.
  - `overflow` stays 1 until a `clr_overflow` pulse.
  - With `clr_overflow` in the same cycle as a dropping push, `overflow`=1.
- **Held request.** Hold `send_req` high for 100 cycles with `data_in`=0x3C. Exactly one frame is sent.
- **Reset during a frame.** Assert `reset_n` low mid-frame, during data bit 3.
  - `tx`=1 immediately, `fifo_count`=0, `tx_busy`=0.
  - With `send_req` held high through reset release, no frame is sent.
- **Full with simultaneous pop.** Fill the FIFO to 4 bytes, then push in the exact cycle the STOP→START pop occurs. The byte is accepted, `overflow`=0, and all bytes are transmitted in order.
